// File: rtl/rob_multiport_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_multiport_pkg : op encodings, entry layout, writeback helper |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package rob_multiport_pkg;

   localparam int ROB_BITS_DEF = 4;
   localparam int NUM_WB_DEF   = 2;

   typedef enum logic [1:0] {
      OP_NORMAL = 2'd0,
      OP_STORE  = 2'd1,
      OP_BRANCH = 2'd2,
      OP_JALR   = 2'd3
   } rob_op_e;

   typedef struct packed {
      logic        valid;
      logic        ready;
      rob_op_e     op;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] alt_pc;
      logic        pred_taken;
      logic [31:0] value;
      logic [31:0] target;
   } rob_entry_t;

   // A branch keeps its resolved direction in value[0]; a JALR keeps its link value.
   function automatic logic [31:0] wb_result(rob_op_e op, logic [31:0] old_value,
                                             logic [31:0] wb_value);
      case (op)
         OP_BRANCH: wb_result = {31'd0, wb_value[0]};
         OP_JALR:   wb_result = old_value;
         default:   wb_result = wb_value;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/rob_multiport_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_multiport_if : issue / writeback / lookup / commit bundle    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface rob_multiport_if #(
   parameter int ROB_BITS = 4,
   parameter int NUM_WB   = 2
);
   logic                       issue_valid;
   logic [1:0]                 issue_op;
   logic [4:0]                 issue_rd;
   logic [31:0]                issue_pc;
   logic [31:0]                issue_alt_pc;
   logic                       issue_pred_taken;
   logic [ROB_BITS-1:0]        issue_id;
   logic                       full;
   logic                       empty;
   logic [NUM_WB-1:0]          wb_valid;
   logic [NUM_WB*ROB_BITS-1:0] wb_id;
   logic [NUM_WB*32-1:0]       wb_value;
   logic [ROB_BITS-1:0]        qry_id_a;
   logic [ROB_BITS-1:0]        qry_id_b;
   logic                       qry_ready_a;
   logic                       qry_ready_b;
   logic [31:0]                qry_value_a;
   logic [31:0]                qry_value_b;
   logic                       commit_valid;
   logic [ROB_BITS-1:0]        commit_id;
   logic [4:0]                 commit_rd;
   logic [31:0]                commit_value;
   logic                       commit_store;
   logic                       flush;
   logic [31:0]                redirect_pc;
   logic                       bp_update_valid;
   logic [31:0]                bp_update_pc;
   logic                       bp_update_taken;

   modport master (
      output issue_valid, issue_op, issue_rd, issue_pc, issue_alt_pc, issue_pred_taken,
      output wb_valid, wb_id, wb_value, qry_id_a, qry_id_b,
      input  issue_id, full, empty, qry_ready_a, qry_ready_b, qry_value_a, qry_value_b,
      input  commit_valid, commit_id, commit_rd, commit_value, commit_store,
      input  flush, redirect_pc, bp_update_valid, bp_update_pc, bp_update_taken
   );

   modport slave (
      input  issue_valid, issue_op, issue_rd, issue_pc, issue_alt_pc, issue_pred_taken,
      input  wb_valid, wb_id, wb_value, qry_id_a, qry_id_b,
      output issue_id, full, empty, qry_ready_a, qry_ready_b, qry_value_a, qry_value_b,
      output commit_valid, commit_id, commit_rd, commit_value, commit_store,
      output flush, redirect_pc, bp_update_valid, bp_update_pc, bp_update_taken
   );
endinterface
`default_nettype wire

// File: rtl/rob_multiport_query_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_query_port : operand lookup with same-cycle writeback bypass |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rob_query_port
   import rob_multiport_pkg::*;
#(
   parameter int ROB_BITS = 4,
   parameter int NUM_WB   = 2
) (
   input  logic                       valid_i [2**ROB_BITS],
   input  logic                       ready_i [2**ROB_BITS],
   input  rob_op_e                    op_i    [2**ROB_BITS],
   input  logic [31:0]                value_i [2**ROB_BITS],
   input  logic [NUM_WB-1:0]          wb_valid_i,
   input  logic [NUM_WB*ROB_BITS-1:0] wb_id_i,
   input  logic [NUM_WB*32-1:0]       wb_value_i,
   input  logic [ROB_BITS-1:0]        qry_id_i,
   output logic                       ready_o,
   output logic [31:0]                value_o
);
   always_comb begin
      ready_o = 1'b0;
      value_o = '0;
      if (valid_i[qry_id_i]) begin
         ready_o = ready_i[qry_id_i];
         value_o = value_i[qry_id_i];
         // Ascending scan lets the highest matching channel win.
         for (int k = 0; k < NUM_WB; k++) begin
            if (wb_valid_i[k] && (wb_id_i[k*ROB_BITS +: ROB_BITS] == qry_id_i)) begin
               ready_o = 1'b1;
               value_o = wb_result(op_i[qry_id_i], value_i[qry_id_i], wb_value_i[k*32 +: 32]);
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/rob_multiport.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rob_multiport : reorder buffer, 1 issue / NUM_WB wb / 1 commit   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rob_multiport
   import rob_multiport_pkg::*;
#(
   parameter int ROB_BITS = ROB_BITS_DEF,
   parameter int NUM_WB   = NUM_WB_DEF
) (
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   rob_multiport_if.slave  rob
);
   localparam int DEPTH = 2**ROB_BITS;

   rob_entry_t          entries_q [DEPTH];
   rob_entry_t          entries_d [DEPTH];
   logic [ROB_BITS-1:0] head_q, head_d, tail_q, tail_d;
   logic [ROB_BITS:0]   count_q, count_d;
   rob_entry_t          head_ent;
   logic                fire;
   logic                do_issue;
   logic [ROB_BITS-1:0] wid;
   logic                ent_valid [DEPTH];
   logic                ent_ready [DEPTH];
   rob_op_e             ent_op    [DEPTH];
   logic [31:0]         ent_value [DEPTH];

   assign head_ent     = entries_q[head_q];
   assign fire         = rdy_in && head_ent.valid && head_ent.ready;
   assign rob.issue_id = tail_q;
   assign rob.full     = (count_q == (ROB_BITS+1)'(DEPTH));
   assign rob.empty    = (count_q == '0);

   always_comb begin
      rob.commit_valid    = fire;
      rob.commit_id       = head_q;
      rob.commit_rd       = head_ent.rd;
      rob.commit_value    = head_ent.value;
      rob.commit_store    = fire && (head_ent.op == OP_STORE);
      rob.bp_update_valid = fire && (head_ent.op == OP_BRANCH);
      rob.bp_update_pc    = head_ent.pc;
      rob.bp_update_taken = head_ent.value[0];
      rob.flush           = 1'b0;
      rob.redirect_pc     = '0;
      if (fire && (head_ent.op == OP_BRANCH) && (head_ent.value[0] != head_ent.pred_taken)) begin
         rob.flush       = 1'b1;
         rob.redirect_pc = head_ent.alt_pc;
      end
      if (fire && (head_ent.op == OP_JALR)) begin
         rob.flush       = 1'b1;
         rob.redirect_pc = head_ent.target;
      end
   end

   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      wid       = '0;
      do_issue  = rob.issue_valid && !rob.full;
      if (rob.flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_d[i].valid = 1'b0;
            entries_d[i].ready = 1'b0;
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         for (int k = 0; k < NUM_WB; k++) begin
            wid = rob.wb_id[k*ROB_BITS +: ROB_BITS];
            if (rob.wb_valid[k] && entries_q[wid].valid) begin
               entries_d[wid].ready = 1'b1;
               if (entries_q[wid].op == OP_JALR)
                  entries_d[wid].target = rob.wb_value[k*32 +: 32] & ~32'd1;
               else
                  entries_d[wid].value = wb_result(entries_q[wid].op, entries_q[wid].value,
                                                   rob.wb_value[k*32 +: 32]);
            end
         end
         if (fire) begin
            entries_d[head_q].valid = 1'b0;
            entries_d[head_q].ready = 1'b0;
            head_d = head_q + 1'b1;
         end
         if (do_issue) begin
            entries_d[tail_q].valid      = 1'b1;
            entries_d[tail_q].ready      = 1'b0;
            entries_d[tail_q].op         = rob_op_e'(rob.issue_op);
            entries_d[tail_q].rd         = (rob.issue_op == OP_STORE) ? 5'd0 : rob.issue_rd;
            entries_d[tail_q].pc         = rob.issue_pc;
            entries_d[tail_q].alt_pc     = rob.issue_alt_pc;
            entries_d[tail_q].pred_taken = rob.issue_pred_taken;
            entries_d[tail_q].value      = (rob.issue_op == OP_JALR) ? rob.issue_pc + 32'd4 : 32'd0;
            entries_d[tail_q].target     = '0;
            tail_d = tail_q + 1'b1;
         end
         case ({do_issue, fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (rdy_in) begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_view
      assign ent_valid[i] = entries_q[i].valid;
      assign ent_ready[i] = entries_q[i].ready;
      assign ent_op[i]    = entries_q[i].op;
      assign ent_value[i] = entries_q[i].value;
   end

   rob_query_port #(.ROB_BITS(ROB_BITS), .NUM_WB(NUM_WB)) u_qry_a (
      .valid_i(ent_valid), .ready_i(ent_ready), .op_i(ent_op), .value_i(ent_value),
      .wb_valid_i(rob.wb_valid), .wb_id_i(rob.wb_id), .wb_value_i(rob.wb_value),
      .qry_id_i(rob.qry_id_a), .ready_o(rob.qry_ready_a), .value_o(rob.qry_value_a)
   );

   rob_query_port #(.ROB_BITS(ROB_BITS), .NUM_WB(NUM_WB)) u_qry_b (
      .valid_i(ent_valid), .ready_i(ent_ready), .op_i(ent_op), .value_i(ent_value),
      .wb_valid_i(rob.wb_valid), .wb_id_i(rob.wb_id), .wb_value_i(rob.wb_value),
      .qry_id_i(rob.qry_id_b), .ready_o(rob.qry_ready_b), .value_o(rob.qry_value_b)
   );
endmodule
`default_nettype wire

// File: tb/tb_rob_multiport.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rob_multiport : directed + random bench with queue model      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_rob_multiport;
   localparam int RB    = 4;
   localparam int NW    = 2;
   localparam int DEPTH = 16;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   logic rdy_in = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;

   rob_multiport_if #(.ROB_BITS(RB), .NUM_WB(NW)) bus ();
   rob_multiport #(.ROB_BITS(RB), .NUM_WB(NW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob(bus)
   );

   always #5 clk_in = ~clk_in;

   // Model: in-order list of live entries, oldest first; op 0..3 = NORMAL/STORE/BRANCH/JALR.
   typedef struct {
      int          id;
      int          op;
      int          rd;
      logic [31:0] pc;
      logic [31:0] alt;
      bit          pred;
      bit          ready;
      bit          taken;
      logic [31:0] value;
      logic [31:0] target;
   } ment_t;
   ment_t mq[$];
   int    mtail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic int mfind(int id);
      foreach (mq[i]) if (mq[i].id == id) return i;
      return -1;
   endfunction

   task automatic idle();
      bus.issue_valid = 0; bus.issue_op = 0; bus.issue_rd = 0; bus.issue_pc = 0;
      bus.issue_alt_pc = 0; bus.issue_pred_taken = 0;
      bus.wb_valid = 0; bus.wb_id = 0; bus.wb_value = 0;
      bus.qry_id_a = 0; bus.qry_id_b = 0;
   endtask

   task automatic set_issue(input int op, input int rd, input logic [31:0] pc,
                            input logic [31:0] alt, input bit pred);
      bus.issue_valid = 1; bus.issue_op = 2'(op); bus.issue_rd = 5'(rd);
      bus.issue_pc = pc; bus.issue_alt_pc = alt; bus.issue_pred_taken = pred;
   endtask

   task automatic set_wb(input int k, input int id, input logic [31:0] v);
      bus.wb_valid[k] = 1'b1;
      bus.wb_id[k*RB +: RB] = RB'(id);
      bus.wb_value[k*32 +: 32] = v;
   endtask

   task automatic model_query(input int id, output bit rdy, output logic [31:0] val, output bit is_br);
      int idx;
      idx = mfind(id);
      rdy = 0; val = 0; is_br = 0;
      if (idx >= 0) begin
         is_br = (mq[idx].op == 2);
         rdy = mq[idx].ready;
         val = mq[idx].value;
         for (int k = 0; k < NW; k++) begin
            if (bus.wb_valid[k] && int'(bus.wb_id[k*RB +: RB]) == id) begin
               rdy = 1;
               if (mq[idx].op <= 1) val = bus.wb_value[k*32 +: 32];
            end
         end
      end
   endtask

   task automatic check_outputs();
      bit fire, exp_flush, rdy_a, rdy_b, br_a, br_b;
      logic [31:0] exp_redir, val_a, val_b;
      check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      check("empty", 32'(bus.empty), 32'(mq.size() == 0));
      check("issue_id", 32'(bus.issue_id), 32'(mtail));
      fire = rdy_in && mq.size() > 0 && mq[0].ready;
      exp_flush = 0; exp_redir = 0;
      check("commit_valid", 32'(bus.commit_valid), 32'(fire));
      check("commit_store", 32'(bus.commit_store), 32'(fire && mq[0].op == 1));
      check("bp_valid", 32'(bus.bp_update_valid), 32'(fire && mq[0].op == 2));
      if (fire) begin
         check("commit_id", 32'(bus.commit_id), 32'(mq[0].id));
         check("commit_rd", 32'(bus.commit_rd), 32'(mq[0].rd));
         if (mq[0].op != 2) check("commit_value", bus.commit_value, mq[0].value);
         if (mq[0].op == 2) begin
            check("bp_pc", bus.bp_update_pc, mq[0].pc);
            check("bp_taken", 32'(bus.bp_update_taken), 32'(mq[0].taken));
            if (mq[0].taken != mq[0].pred) begin exp_flush = 1; exp_redir = mq[0].alt; end
         end
         if (mq[0].op == 3) begin exp_flush = 1; exp_redir = mq[0].target; end
      end
      check("flush", 32'(bus.flush), 32'(exp_flush));
      check("redirect_pc", bus.redirect_pc, exp_redir);
      model_query(int'(bus.qry_id_a), rdy_a, val_a, br_a);
      model_query(int'(bus.qry_id_b), rdy_b, val_b, br_b);
      check("qry_ready_a", 32'(bus.qry_ready_a), 32'(rdy_a));
      check("qry_ready_b", 32'(bus.qry_ready_b), 32'(rdy_b));
      if (!br_a) check("qry_value_a", bus.qry_value_a, val_a);
      if (!br_b) check("qry_value_b", bus.qry_value_b, val_b);
   endtask

   task automatic model_edge();
      bit fire, full_pre;
      int idx;
      ment_t e;
      if (!rdy_in) return;
      full_pre = (mq.size() == DEPTH);
      fire = mq.size() > 0 && mq[0].ready;
      if (fire && ((mq[0].op == 2 && mq[0].taken != mq[0].pred) || mq[0].op == 3)) begin
         mq.delete();
         mtail = 0;
         return;
      end
      for (int k = 0; k < NW; k++) begin
         if (bus.wb_valid[k]) begin
            idx = mfind(int'(bus.wb_id[k*RB +: RB]));
            if (idx >= 0) begin
               mq[idx].ready = 1;
               case (mq[idx].op)
                  2:       mq[idx].taken  = bus.wb_value[k*32];
                  3:       mq[idx].target = bus.wb_value[k*32 +: 32] & 32'hFFFF_FFFE;
                  default: mq[idx].value  = bus.wb_value[k*32 +: 32];
               endcase
            end
         end
      end
      if (fire) void'(mq.pop_front());
      if (bus.issue_valid && !full_pre) begin
         e.id = mtail; e.op = int'(bus.issue_op);
         e.rd = (e.op == 1) ? 0 : int'(bus.issue_rd);
         e.pc = bus.issue_pc; e.alt = bus.issue_alt_pc; e.pred = bus.issue_pred_taken;
         e.ready = 0; e.taken = 0; e.target = 0;
         e.value = (e.op == 3) ? bus.issue_pc + 32'd4 : 32'd0;
         mq.push_back(e);
         mtail = (mtail + 1) % DEPTH;
      end
   endtask

   task automatic cycle();
      #2;
      check_outputs();
      @(posedge clk_in);
      model_edge();
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_full"}, 32'(bus.full), 0);
      check({tag, "_empty"}, 32'(bus.empty), 1);
      check({tag, "_issue_id"}, 32'(bus.issue_id), 0);
      check({tag, "_commit_valid"}, 32'(bus.commit_valid), 0);
      check({tag, "_commit_store"}, 32'(bus.commit_store), 0);
      check({tag, "_flush"}, 32'(bus.flush), 0);
      check({tag, "_redirect"}, bus.redirect_pc, 0);
      check({tag, "_bp_valid"}, 32'(bus.bp_update_valid), 0);
      check({tag, "_qry_ready"}, 32'({bus.qry_ready_a, bus.qry_ready_b}), 0);
   endtask

   task automatic drain();
      idle();
      for (int n = 0; n < 40 && mq.size() > 0; n++) begin
         set_wb(0, mq[0].id, $urandom);
         cycle();
         idle();
      end
      cycle();
      check("drained", 32'(bus.empty), 1);
   endtask

   initial begin
      int id, r;
      idle();
      #1;
      check_reset_outputs("rst");
      #6 rst_in = 1'b1; rdy_in = 1'b1;
      @(posedge clk_in); #1;

      // Fill to capacity; the 17th issue must be dropped.
      for (int i = 0; i < 17; i++) begin
         set_issue(0, i + 1, 32'h1000 + 32'(4 * i), 0, 0);
         cycle();
      end
      idle();
      #1;
      check("full_after_16", 32'(bus.full), 1);
      check("tail_wrapped", 32'(bus.issue_id), 0);
      drain();

      // Writeback bypass to lookup, then commit of that value.
      id = mtail;
      set_issue(0, 5, 32'h2000, 0, 0);
      cycle();
      idle();
      set_wb(1, id, 32'h1234);
      bus.qry_id_a = RB'(id);
      #2;
      check("bypass_ready", 32'(bus.qry_ready_a), 1);
      check("bypass_value", bus.qry_value_a, 32'h1234);
      cycle();
      idle();
      #2;
      check("commit_rd5", 32'(bus.commit_rd), 5);
      check("commit_1234", bus.commit_value, 32'h1234);
      cycle();

      // Mispredicted branch.
      id = mtail;
      set_issue(2, 0, 32'h80, 32'h100, 1);
      cycle();
      idle();
      set_wb(0, id, 32'h0);
      cycle();
      idle();
      #2;
      check("br_flush", 32'(bus.flush), 1);
      check("br_redirect", bus.redirect_pc, 32'h100);
      check("br_taken", 32'(bus.bp_update_taken), 0);
      cycle();
      check("br_empty", 32'(bus.empty), 1);

      // JALR with a concurrent issue that must be discarded.
      id = mtail;
      set_issue(3, 1, 32'h40, 0, 0);
      cycle();
      idle();
      set_wb(1, id, 32'h203);
      cycle();
      idle();
      set_issue(0, 9, 32'h500, 0, 0);
      #2;
      check("jalr_value", bus.commit_value, 32'h44);
      check("jalr_redirect", bus.redirect_pc, 32'h202);
      check("jalr_flush", 32'(bus.flush), 1);
      cycle();
      idle();
      check("jalr_empty", 32'(bus.empty), 1);

      // STORE held off by rdy_in low, then retired.
      set_issue(1, 7, 32'h60, 0, 0);
      cycle();
      idle();
      set_wb(0, 0, 32'hDEAD);
      cycle();
      idle();
      rdy_in = 1'b0;
      #2;
      check("st_hold_valid", 32'(bus.commit_valid), 0);
      check("st_hold_store", 32'(bus.commit_store), 0);
      cycle();
      rdy_in = 1'b1;
      #2;
      check("st_store", 32'(bus.commit_store), 1);
      check("st_rd0", 32'(bus.commit_rd), 0);
      cycle();

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         idle();
         rdy_in = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 9) < 6) begin
            r = $urandom_range(0, 99);
            set_issue(r < 60 ? 0 : r < 75 ? 1 : r < 93 ? 2 : 3, $urandom_range(0, 31),
                      $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
         end
         for (int k = 0; k < NW; k++) begin
            if ($urandom_range(0, 9) < 5) begin
               if (mq.size() > 0 && $urandom_range(0, 4) != 0)
                  set_wb(k, mq[$urandom_range(0, mq.size() - 1)].id, $urandom);
               else
                  set_wb(k, $urandom_range(0, DEPTH - 1), $urandom);
            end
         end
         bus.qry_id_a = (mq.size() > 0) ? RB'(mq[$urandom_range(0, mq.size() - 1)].id)
                                        : RB'($urandom_range(0, DEPTH - 1));
         bus.qry_id_b = RB'($urandom_range(0, DEPTH - 1));
         cycle();
      end

      // Asynchronous reset mid-cycle with five live entries.
      rdy_in = 1'b1;
      drain();
      for (int i = 0; i < 5; i++) begin
         set_issue(0, i + 1, 32'(i * 4), 0, 0);
         cycle();
      end
      idle();
      set_wb(0, mq[0].id, 32'h55);
      #2;
      check("pre_rst_count", 32'(mq.size()), 5);
      check("pre_rst_empty", 32'(bus.empty), 0);
      rst_in = 1'b0;
      #1;
      bus.qry_id_a = RB'(mq[0].id);
      #1;
      check_reset_outputs("async");
      mq.delete();
      mtail = 0;
      idle();
      @(negedge clk_in);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      for (int n = 0; n < 20; n++) begin
         idle();
         if ($urandom_range(0, 1) == 1) set_issue(0, $urandom_range(0, 31), $urandom, 0, 0);
         if (mq.size() > 0) set_wb(1, mq[0].id, $urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
`default_nettype wire
